// File: rtl/gene_line_packer.sv
// Packs a stream of ASCII nucleotides into 2-bit-per-base lines of BASES_PER_LINE
// bases, with one output register and one stalled line held in the accumulator.
module gene_line_packer #(
   parameter int BASES_PER_LINE = 100
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [7:0]                               in_char,
   input  logic                                     in_valid,
   input  logic                                     in_last,
   output logic                                     in_ready,
   output logic [2*BASES_PER_LINE-1:0]              out_line,
   output logic [$clog2(BASES_PER_LINE+1)-1:0]      out_count,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic                                     bad_char
);

   localparam int LW = 2 * BASES_PER_LINE;
   localparam int CW = $clog2(BASES_PER_LINE + 1);
   localparam logic [CW-1:0] LAST_POS = CW'(BASES_PER_LINE - 1);

   logic [LW-1:0] acc;
   logic [LW-1:0] line_word;
   logic [CW-1:0] cnt;
   logic [CW-1:0] pend_count;
   logic          acc_full;
   logic [1:0]    code;
   logic          known;
   logic          take;
   logic          drain;
   logic          complete;

   always_comb begin
      code  = 2'b00;
      known = 1'b1;
      case (in_char)
         "A", "a": code = 2'b00;
         "C", "c": code = 2'b01;
         "G", "g": code = 2'b10;
         "T", "t": code = 2'b11;
         default:  known = 1'b0;
      endcase
   end

   // Unfilled positions of acc are always zero, so the new base is simply written in place.
   always_comb begin
      line_word = acc;
      line_word[2*cnt +: 2] = code;
   end

   assign take     = in_valid && in_ready;
   assign drain    = out_valid && out_ready;
   assign complete = in_last || (cnt == LAST_POS);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         cnt        <= '0;
         pend_count <= '0;
         acc_full   <= 1'b0;
         in_ready   <= 1'b1;
         out_line   <= '0;
         out_count  <= '0;
         out_valid  <= 1'b0;
         bad_char   <= 1'b0;
      end else begin
         if (take && !known)
            bad_char <= 1'b1;
         if (drain)
            out_valid <= 1'b0;
         if (take) begin
            if (complete) begin
               cnt <= '0;
               if (!out_valid || drain) begin
                  out_line  <= line_word;
                  out_count <= cnt + CW'(1);
                  out_valid <= 1'b1;
                  acc       <= '0;
               end else begin
                  // Output register busy: park the finished line and stop accepting.
                  acc        <= line_word;
                  pend_count <= cnt + CW'(1);
                  acc_full   <= 1'b1;
                  in_ready   <= 1'b0;
               end
            end else begin
               acc <= line_word;
               cnt <= cnt + CW'(1);
            end
         end else if (acc_full && drain) begin
            out_line  <= acc;
            out_count <= pend_count;
            out_valid <= 1'b1;
            acc       <= '0;
            acc_full  <= 1'b0;
            in_ready  <= 1'b1;
         end
      end
   end

endmodule
